ppu_reg_bus_master: RTL and testbench



---
 rtl/ppu_reg_bus_master.sv | 153 +++++++++++++++
 tb/tb_ppu_reg_bus_master.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_reg_bus_master.sv
// PPU register-port initiator: one byte per SETUP/ACTIVE/HOLD sequence, wide writes to RS 5/6 as two bytes.
// ack after T_SETUP+T_ACTIVE+T_HOLD cycles per byte; req is sampled only in IDLE (ack cycle included), never queued.
module ppu_reg_bus_master #(
  parameter int T_SETUP  = 1,
  parameter int T_ACTIVE = 2,
  parameter int T_HOLD   = 1
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        req,
  input  logic        cmd_rnw,
  input  logic [2:0]  cmd_rs,
  input  logic        cmd_wide,
  input  logic [15:0] cmd_data,
  output logic        ack,
  output logic        busy,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [2:0]  RS,
  output logic        RnW,
  output logic        n_DBE,
  inout  wire  [7:0]  CPU_DB,
  output logic        scnd
);

  localparam logic [3:0] SETUP_LD  = 4'(T_SETUP - 1);
  localparam logic [3:0] ACTIVE_LD = 4'(T_ACTIVE - 1);
  localparam logic [3:0] HOLD_LD   = 4'(T_HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACTIVE, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rnw_q, rnw_d;
  logic [2:0]  rs_q, rs_d;
  logic        hi_q, hi_d;
  logic [15:0] data_q, data_d;
  logic        ack_q, ack_d;
  logic        rd_valid_q, rd_valid_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        scnd_q, scnd_d;

  logic        toggle_reg;
  logic        drive_en;
  logic [7:0]  cur_byte;

  // hi_q marks that the high byte of a wide write is still to be sent
  assign cur_byte   = hi_q ? data_q[15:8] : data_q[7:0];
  assign toggle_reg = (rs_q == 3'd5) || (rs_q == 3'd6);
  assign drive_en   = (state_q != S_IDLE) && !rnw_q;

  assign CPU_DB   = drive_en ? cur_byte : 8'hzz;
  assign RS       = rs_q;
  assign RnW      = (state_q == S_IDLE) ? 1'b1 : rnw_q;
  assign n_DBE    = (state_q != S_ACTIVE);
  assign busy     = (state_q != S_IDLE);
  assign ack      = ack_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign scnd     = scnd_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rnw_d      = rnw_q;
    rs_d       = rs_q;
    hi_d       = hi_q;
    data_d     = data_q;
    ack_d      = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    scnd_d     = scnd_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          rnw_d   = cmd_rnw;
          rs_d    = cmd_rs;
          data_d  = cmd_data;
          hi_d    = cmd_wide && !cmd_rnw && ((cmd_rs == 3'd5) || (cmd_rs == 3'd6));
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACTIVE;
          cnt_d   = ACTIVE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACTIVE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
          if (rnw_q) rd_data_d = CPU_DB;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) begin
          // mirror the PPU write toggle: each byte to 5/6 flips it, a status read clears it
          if (!rnw_q && toggle_reg) scnd_d = !scnd_q;
          if (rnw_q && (rs_q == 3'd2)) scnd_d = 1'b0;
          if (hi_q) begin
            hi_d    = 1'b0;
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d    = S_IDLE;
            cnt_d      = 4'd0;
            ack_d      = 1'b1;
            rd_valid_d = rnw_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      rnw_q      <= 1'b1;
      rs_q       <= 3'd0;
      hi_q       <= 1'b0;
      data_q     <= 16'd0;
      ack_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'd0;
      scnd_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rnw_q      <= rnw_d;
      rs_q       <= rs_d;
      hi_q       <= hi_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      scnd_q     <= scnd_d;
    end
  end

endmodule

// File: tb/tb_ppu_reg_bus_master.sv
// Bench for ppu_reg_bus_master: directed scenarios plus random commands against a cycle-count model.
module tb_ppu_reg_bus_master;
  localparam int TS = 1, TA = 2, TH = 1;
  localparam int L = TS + TA + TH;

  logic        CLK, RES, req, cmd_rnw, cmd_wide;
  logic [2:0]  cmd_rs;
  logic [15:0] cmd_data;
  logic        ack, busy, rd_valid, RnW, n_DBE, scnd;
  logic [7:0]  rd_data;
  logic [2:0]  RS;
  wire  [7:0]  cpu_db;
  logic        tb_db_en;
  logic [7:0]  tb_db_val;

  assign cpu_db = tb_db_en ? tb_db_val : 8'hzz;

  ppu_reg_bus_master #(.T_SETUP(TS), .T_ACTIVE(TA), .T_HOLD(TH)) dut (
    .CLK(CLK), .RES(RES), .req(req), .cmd_rnw(cmd_rnw), .cmd_rs(cmd_rs),
    .cmd_wide(cmd_wide), .cmd_data(cmd_data), .ack(ack), .busy(busy),
    .rd_data(rd_data), .rd_valid(rd_valid), .RS(RS), .RnW(RnW),
    .n_DBE(n_DBE), .CPU_DB(cpu_db), .scnd(scnd)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic       scnd_m;
  logic [7:0] rd_m;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: byte count, toggle shadow and read register from the command alone.
  function automatic int n_bytes(input logic rnw, input logic [2:0] rs, input logic wide);
    return (wide && !rnw && (rs == 3'd5 || rs == 3'd6)) ? 2 : 1;
  endfunction

  task automatic model_update(input logic rnw, input logic [2:0] rs, input logic wide, input logic [7:0] rbyte);
    if (!rnw && (rs == 3'd5 || rs == 3'd6)) repeat (n_bytes(rnw, rs, wide)) scnd_m = ~scnd_m;
    if (rnw && rs == 3'd2) scnd_m = 1'b0;
    if (rnw) rd_m = rbyte;
  endtask

  // Issues one command and watches it cycle by cycle; perr counts per-cycle bus deviations.
  task automatic do_cmd(input logic rnw, input logic [2:0] rs, input logic wide, input logic [15:0] data,
                        input logic [7:0] rbyte, output int ack_cyc, output int perr,
                        output logic [7:0] rd, output logic rv, output logic scnd_mid, output logic scnd_end);
    int nb, ph;
    logic weff;
    logic [7:0] exp_b;
    nb = n_bytes(rnw, rs, wide);
    weff = (nb == 2);
    ack_cyc = -1; perr = 0; rd = 8'h00; rv = 1'b0; scnd_mid = 1'b0; scnd_end = 1'b0;
    @(posedge CLK); #1;
    req = 1'b1; cmd_rnw = rnw; cmd_rs = rs; cmd_wide = wide; cmd_data = data;
    tb_db_val = rbyte; tb_db_en = rnw;
    @(posedge CLK); #1;
    req = 1'b0;
    cmd_rnw = 1'($urandom); cmd_rs = 3'($urandom); cmd_wide = 1'($urandom); cmd_data = 16'($urandom);
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (ack === 1'b1) begin
        ack_cyc = k; rd = rd_data; rv = rd_valid; scnd_end = scnd;
        if (busy !== 1'b0 || RnW !== 1'b1 || n_DBE !== 1'b1 || RS !== rs) perr++;
        break;
      end
      if (k >= nb * L) begin
        perr++;
      end else begin
        ph = k % L;
        exp_b = rnw ? rbyte : ((weff && k < L) ? data[15:8] : data[7:0]);
        if (n_DBE !== !(ph >= TS && ph < TS + TA)) perr++;
        if (RnW !== rnw) perr++;
        if (RS !== rs) perr++;
        if (busy !== 1'b1) perr++;
        if (rd_valid !== 1'b0) perr++;
        if (cpu_db !== exp_b) perr++;
        if (k == L) scnd_mid = scnd;
      end
    end
    tb_db_en = 1'b0;
  endtask

  task automatic test_reset;
    RES = 1'b1; req = 1'b0; cmd_rnw = 1'b0; cmd_rs = 3'd0; cmd_wide = 1'b0; cmd_data = 16'h0;
    tb_db_en = 1'b0; tb_db_val = 8'h00;
    repeat (6) begin
      @(posedge CLK); #1;
      req = 1'($urandom); cmd_rs = 3'($urandom); cmd_data = 16'($urandom);
    end
    @(negedge CLK);
    n_cmp++; if (n_DBE !== 1'b1) begin n_bad++; $display("FAIL reset_n_dbe: got %b want 1", n_DBE); end
    n_cmp++; if (RnW !== 1'b1) begin n_bad++; $display("FAIL reset_rnw: got %b want 1", RnW); end
    n_cmp++; if (ack !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_ack_busy: got %b%b want 00", ack, busy); end
    n_cmp++; if (scnd !== 1'b0) begin n_bad++; $display("FAIL reset_scnd: got %b want 0", scnd); end
    n_cmp++; if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd: got %h/%b want 00/0", rd_data, rd_valid); end
    n_cmp++; if (RS !== 3'd0) begin n_bad++; $display("FAIL reset_rs: got %0d want 0", RS); end
    tb_db_en = 1'b1; tb_db_val = 8'h5A; #1;
    n_cmp++; if (cpu_db !== 8'h5A) begin n_bad++; $display("FAIL reset_hiz_5a: got %h want 5a", cpu_db); end
    tb_db_val = 8'hA5; #1;
    n_cmp++; if (cpu_db !== 8'hA5) begin n_bad++; $display("FAIL reset_hiz_a5: got %h want a5", cpu_db); end
    tb_db_en = 1'b0; req = 1'b0;
    @(negedge CLK); RES = 1'b0;
    scnd_m = 1'b0; rd_m = 8'h00;
  endtask

  task automatic test_single_write;
    int ac, pe; logic [7:0] rd; logic rv, sm, se;
    do_cmd(1'b0, 3'd1, 1'b0, 16'h001E, 8'h00, ac, pe, rd, rv, sm, se);
    model_update(1'b0, 3'd1, 1'b0, 8'h00);
    n_cmp++; if (ac !== L) begin n_bad++; $display("FAIL single_ack_cycle: got %0d want %0d", ac, L); end
    n_cmp++; if (pe !== 0) begin n_bad++; $display("FAIL single_bus_pattern: got %0d bad cycles want 0", pe); end
    n_cmp++; if (se !== scnd_m) begin n_bad++; $display("FAIL single_scnd: got %b want %b", se, scnd_m); end
    n_cmp++; if (rv !== 1'b0) begin n_bad++; $display("FAIL single_rd_valid: got %b want 0", rv); end
  endtask

  task automatic test_wide_write;
    int ac, pe; logic [7:0] rd; logic rv, sm, se, s0;
    s0 = scnd_m;
    do_cmd(1'b0, 3'd6, 1'b1, 16'h3F10, 8'h00, ac, pe, rd, rv, sm, se);
    model_update(1'b0, 3'd6, 1'b1, 8'h00);
    n_cmp++; if (ac !== 2 * L) begin n_bad++; $display("FAIL wide_ack_cycle: got %0d want %0d", ac, 2 * L); end
    n_cmp++; if (pe !== 0) begin n_bad++; $display("FAIL wide_bus_pattern: got %0d bad cycles want 0", pe); end
    n_cmp++; if (sm !== ~s0) begin n_bad++; $display("FAIL wide_scnd_mid: got %b want %b", sm, ~s0); end
    n_cmp++; if (se !== scnd_m) begin n_bad++; $display("FAIL wide_scnd_end: got %b want %b", se, scnd_m); end
  endtask

  task automatic test_read_rs2;
    int ac, pe; logic [7:0] rd; logic rv, sm, se;
    do_cmd(1'b0, 3'd5, 1'b0, 16'($urandom), 8'h00, ac, pe, rd, rv, sm, se);
    model_update(1'b0, 3'd5, 1'b0, 8'h00);
    n_cmp++; if (se !== scnd_m) begin n_bad++; $display("FAIL rs5_scnd: got %b want %b", se, scnd_m); end
    do_cmd(1'b1, 3'd2, 1'b0, 16'h0000, 8'h80, ac, pe, rd, rv, sm, se);
    model_update(1'b1, 3'd2, 1'b0, 8'h80);
    n_cmp++; if (ac !== L) begin n_bad++; $display("FAIL read_ack_cycle: got %0d want %0d", ac, L); end
    n_cmp++; if (pe !== 0) begin n_bad++; $display("FAIL read_bus_pattern: got %0d bad cycles want 0", pe); end
    n_cmp++; if (rd !== rd_m) begin n_bad++; $display("FAIL read_rd_data: got %h want %h", rd, rd_m); end
    n_cmp++; if (rv !== 1'b1) begin n_bad++; $display("FAIL read_rd_valid: got %b want 1", rv); end
    n_cmp++; if (se !== scnd_m) begin n_bad++; $display("FAIL read_scnd: got %b want %b", se, scnd_m); end
    tb_db_en = 1'b1; tb_db_val = 8'h5A; #1;
    n_cmp++; if (cpu_db !== 8'h5A) begin n_bad++; $display("FAIL idle_hiz: got %h want 5a", cpu_db); end
    tb_db_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    int acks, ack_at0, ack_at1;
    logic prev_n;
    logic [7:0] strobes[$];
    acks = 0; ack_at0 = -1; ack_at1 = -1; prev_n = 1'b1;
    @(posedge CLK); #1;
    req = 1'b1; cmd_rnw = 1'b0; cmd_rs = 3'd1; cmd_wide = 1'b0; cmd_data = 16'h00C3; tb_db_en = 1'b0;
    @(posedge CLK); #1;
    cmd_rs = 3'd3; cmd_data = 16'h005A;
    for (int k = 0; k < 2 * L + 8; k++) begin
      @(negedge CLK);
      if (ack === 1'b1) begin
        if (acks == 0) ack_at0 = k;
        if (acks == 1) ack_at1 = k;
        acks++;
      end
      if (n_DBE === 1'b0 && prev_n === 1'b1) strobes.push_back(cpu_db);
      prev_n = n_DBE;
      if (k == L + 1) begin req = 1'b0; cmd_data = 16'($urandom); end
      if (k == L + 2) req = 1'b1;
      if (k == L + 3) req = 1'b0;
    end
    n_cmp++; if (acks !== 2) begin n_bad++; $display("FAIL b2b_ack_count: got %0d want 2", acks); end
    n_cmp++; if (ack_at0 !== L) begin n_bad++; $display("FAIL b2b_first_ack: got %0d want %0d", ack_at0, L); end
    n_cmp++; if (ack_at1 !== 2 * L + 1) begin n_bad++; $display("FAIL b2b_second_ack: got %0d want %0d", ack_at1, 2 * L + 1); end
    n_cmp++; if (strobes.size() !== 2) begin n_bad++; $display("FAIL b2b_strobe_count: got %0d want 2", strobes.size()); end
    else begin
      n_cmp++; if (strobes[0] !== 8'hC3) begin n_bad++; $display("FAIL b2b_byte0: got %h want c3", strobes[0]); end
      n_cmp++; if (strobes[1] !== 8'h5A) begin n_bad++; $display("FAIL b2b_byte1: got %h want 5a", strobes[1]); end
    end
    n_cmp++; if (scnd !== scnd_m) begin n_bad++; $display("FAIL b2b_scnd: got %b want %b", scnd, scnd_m); end
  endtask

  task automatic test_reset_mid;
    int ac, pe, acks; logic [7:0] rd, rb; logic rv, sm, se, seen;
    do_cmd(1'b0, 3'd5, 1'b0, 16'h0011, 8'h00, ac, pe, rd, rv, sm, se);
    model_update(1'b0, 3'd5, 1'b0, 8'h00);
    @(posedge CLK); #1;
    req = 1'b1; cmd_rnw = 1'b0; cmd_rs = 3'd6; cmd_wide = 1'b1; cmd_data = 16'hBEEF;
    @(posedge CLK); #1;
    req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge CLK);
      if (n_DBE === 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rstmid_strobe_seen: got %b want 1", seen); end
    n_cmp++; if (scnd !== 1'b1) begin n_bad++; $display("FAIL rstmid_scnd_before: got %b want 1", scnd); end
    #1 RES = 1'b1; #1;
    n_cmp++; if (n_DBE !== 1'b1 || RnW !== 1'b1) begin n_bad++; $display("FAIL rstmid_strobe: got n_DBE=%b RnW=%b want 1 1", n_DBE, RnW); end
    n_cmp++; if (busy !== 1'b0 || scnd !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_scnd: got %b%b want 00", busy, scnd); end
    tb_db_en = 1'b1; tb_db_val = 8'hA5; #1;
    n_cmp++; if (cpu_db !== 8'hA5) begin n_bad++; $display("FAIL rstmid_hiz: got %h want a5", cpu_db); end
    tb_db_en = 1'b0;
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (ack === 1'b1) acks++;
      if (k == 2) RES = 1'b0;
    end
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL rstmid_no_ack: got %0d want 0", acks); end
    scnd_m = 1'b0; rd_m = 8'h00;
    rb = 8'($urandom);
    do_cmd(1'b1, 3'd0, 1'b0, 16'h0, rb, ac, pe, rd, rv, sm, se);
    model_update(1'b1, 3'd0, 1'b0, rb);
    n_cmp++; if (ac !== L || pe !== 0) begin n_bad++; $display("FAIL rstmid_next_cmd: got ack@%0d bad=%0d want ack@%0d bad=0", ac, pe, L); end
    n_cmp++; if (rd !== rd_m) begin n_bad++; $display("FAIL rstmid_next_rd: got %h want %h", rd, rd_m); end
  endtask

  task automatic test_random;
    int ac, pe, nb; logic [7:0] rd, rb; logic rv, sm, se, rnw, wide, s0; logic [2:0] rs; logic [15:0] d;
    for (int i = 0; i < 40; i++) begin
      rnw = 1'($urandom); wide = 1'($urandom); d = 16'($urandom); rb = 8'($urandom);
      rs = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(5, 6)) : 3'($urandom);
      if ($urandom_range(0, 3) == 0) rs = 3'd2;
      nb = n_bytes(rnw, rs, wide);
      s0 = scnd_m;
      do_cmd(rnw, rs, wide, d, rb, ac, pe, rd, rv, sm, se);
      model_update(rnw, rs, wide, rb);
      n_cmp++; if (ac !== nb * L) begin n_bad++; $display("FAIL rand%0d_ack_cycle: got %0d want %0d", i, ac, nb * L); end
      n_cmp++; if (pe !== 0) begin n_bad++; $display("FAIL rand%0d_bus_pattern: got %0d bad cycles want 0", i, pe); end
      n_cmp++; if (rd !== rd_m || rv !== rnw) begin n_bad++; $display("FAIL rand%0d_read: got %h/%b want %h/%b", i, rd, rv, rd_m, rnw); end
      n_cmp++; if (se !== scnd_m) begin n_bad++; $display("FAIL rand%0d_scnd: got %b want %b", i, se, scnd_m); end
      if (nb == 2) begin
        n_cmp++; if (sm !== ~s0) begin n_bad++; $display("FAIL rand%0d_scnd_mid: got %b want %b", i, sm, ~s0); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_wide_write();
    test_read_rs2();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
